// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, WB source-select codes, occupancy states and pending-entry type
package wb_arbiter_pkg;
    localparam int PEND_DEPTH = 2;
    localparam int RA_W = 5;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_DM  = 2'd1,
        WB_SEL_PC8 = 2'd2
    } wb_sel_e;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;
    typedef struct packed {
        logic [RA_W-1:0]   addr;
        logic [DATA_W-1:0] data;
    } pend_entry_t;
endpackage

// File: rtl/wb_pend_fifo.sv
// wb_pend_fifo: 2-entry in-order MDU pending FIFO with address kill and EMPTY/ONE/FULL occupancy
module wb_pend_fifo
    import wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  pend_entry_t       push_ent_i,
    input  logic              pop_i,
    input  logic              kill_en_i,
    input  logic [RA_W-1:0]   kill_addr_i,
    input  logic [RA_W-1:0]   chk_addr_i,
    output pend_entry_t       head_o,
    output logic              head_live_o,
    output logic              head_kill_o,
    output logic [1:0]        cnt_o,
    output logic              chk_hit_o
);
    logic [1:0] state_q, state_d;
    logic [1:0] n;
    pend_entry_t ent_q [PEND_DEPTH];
    pend_entry_t ent_d [PEND_DEPTH];
    logic live0, live1, kill0, kill1, keep0, keep1;
    assign live0 = state_q != OCC_EMPTY;
    assign live1 = state_q == OCC_FULL;
    assign kill0 = live0 && kill_en_i && ent_q[0].addr == kill_addr_i;
    assign kill1 = live1 && kill_en_i && ent_q[1].addr == kill_addr_i;
    assign keep0 = live0 && !kill0 && !pop_i;
    assign keep1 = live1 && !kill1;
    // survivors compact toward the head, then the push lands behind them
    always_comb begin
        ent_d[0] = keep0 ? ent_q[0] : keep1 ? ent_q[1] : push_ent_i;
        ent_d[1] = (keep0 && keep1) ? ent_q[1] : push_ent_i;
        n = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push_i};
        state_d = n == 2'd0 ? OCC_EMPTY : n == 2'd1 ? OCC_ONE : OCC_FULL;
    end
    always_ff @(posedge clk) begin
        state_q <= !reset ? OCC_EMPTY : state_d;
        ent_q <= ent_d;
    end
    assign head_o = ent_q[0];
    assign head_live_o = live0;
    assign head_kill_o = kill0;
    assign cnt_o = state_q;
    assign chk_hit_o = (live0 && ent_q[0].addr != '0 && ent_q[0].addr == chk_addr_i)
                    || (live1 && ent_q[1].addr != '0 && ent_q[1].addr == chk_addr_i);
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the GRF write port between the WB stage and the MDU pending FIFO
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 3
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [RA_W-1:0]   pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mdu_valid,
    input  logic [RA_W-1:0]   mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic [RA_W-1:0]   chk_addr,
    output logic              chk_hit,
    output logic              grf_we,
    output logic [RA_W-1:0]   grf_addr,
    output logic [DATA_W-1:0] grf_data,
    output logic [1:0]        pend_cnt,
    output logic              stall_req
);
    localparam int AGE_W = $clog2(STARVE_LIM + 2);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);
    logic grant, pop, push, head_live, head_kill;
    pend_entry_t head;
    logic grf_we_q, grf_we_d, stall_q, stall_d;
    logic [RA_W-1:0] grf_addr_q, grf_addr_d;
    logic [DATA_W-1:0] grf_data_q, grf_data_d;
    logic [AGE_W-1:0] age_q, age_d;
    assign grant = pipe_we && pipe_addr != '0;
    assign pop = !grant && head_live;
    assign mdu_ready = pend_cnt != OCC_FULL;
    assign push = mdu_valid && mdu_ready && mdu_addr != '0;
    wb_pend_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_ent_i  ('{addr: mdu_addr, data: mdu_data}),
        .pop_i       (pop),
        .kill_en_i   (grant),
        .kill_addr_i (pipe_addr),
        .chk_addr_i  (chk_addr),
        .head_o      (head),
        .head_live_o (head_live),
        .head_kill_o (head_kill),
        .cnt_o       (pend_cnt),
        .chk_hit_o   (chk_hit)
    );
    // age restarts whenever the head entry changes or leaves
    always_comb begin
        grf_we_d = grant || pop;
        grf_addr_d = grant ? pipe_addr : pop ? head.addr : grf_addr_q;
        grf_data_d = grant ? pipe_data : pop ? head.data : grf_data_q;
        age_d = (!head_live || pop || head_kill) ? '0 : age_q == AGE_LIM ? age_q : age_q + 1'b1;
        stall_d = age_d == AGE_LIM;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            grf_we_q <= 1'b0;
            grf_addr_q <= '0;
            grf_data_q <= '0;
            age_q <= '0;
            stall_q <= 1'b0;
        end else begin
            grf_we_q <= grf_we_d;
            grf_addr_q <= grf_addr_d;
            grf_data_q <= grf_data_d;
            age_q <= age_d;
            stall_q <= stall_d;
        end
    end
    assign grf_we = grf_we_q;
    assign grf_addr = grf_addr_q;
    assign grf_data = grf_data_q;
    assign stall_req = stall_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector-table and sequence checks for the WB write-port arbiter
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic reset, pipe_we, mdu_valid, mdu_ready, chk_hit, grf_we, stall_req;
    logic [4:0] pipe_addr, mdu_addr, chk_addr, grf_addr;
    logic [31:0] pipe_data, mdu_data, grf_data;
    logic [1:0] pend_cnt;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic r, pwe, mv, rdy, hit, we, st;
        logic [4:0] pa, ma, ca, ga;
        logic [31:0] pd, md, gd;
        logic [1:0] cnt;
    } vec_t;
    vec_t tbl[$];
    always #5 clk = ~clk;
    wb_arbiter #(.STARVE_LIM(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_addr (pipe_addr),
        .pipe_data (pipe_data),
        .mdu_valid (mdu_valid),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .grf_we    (grf_we),
        .grf_addr  (grf_addr),
        .grf_data  (grf_data),
        .pend_cnt  (pend_cnt),
        .stall_req (stall_req)
    );
    function automatic vec_t v(int r, int pwe, int pa, int pd, int mv, int ma, int md, int ca,
                               int rdy, int hit, int we, int ga, int gd, int cnt, int st);
        vec_t x;
        x.r = 1'(r); x.pwe = 1'(pwe); x.pa = 5'(pa); x.pd = 32'(pd);
        x.mv = 1'(mv); x.ma = 5'(ma); x.md = 32'(md); x.ca = 5'(ca);
        x.rdy = 1'(rdy); x.hit = 1'(hit); x.we = 1'(we); x.ga = 5'(ga);
        x.gd = 32'(gd); x.cnt = 2'(cnt); x.st = 1'(st);
        return x;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic apply(input vec_t x, input int idx);
        reset = x.r; pipe_we = x.pwe; pipe_addr = x.pa; pipe_data = x.pd;
        mdu_valid = x.mv; mdu_addr = x.ma; mdu_data = x.md; chk_addr = x.ca;
        #1;
        chk($sformatf("v%0d mdu_ready", idx), 32'(mdu_ready), 32'(x.rdy));
        chk($sformatf("v%0d chk_hit", idx), 32'(chk_hit), 32'(x.hit));
        tick();
        chk($sformatf("v%0d grf_we", idx), 32'(grf_we), 32'(x.we));
        chk($sformatf("v%0d grf_addr", idx), 32'(grf_addr), 32'(x.ga));
        chk($sformatf("v%0d grf_data", idx), grf_data, x.gd);
        chk($sformatf("v%0d pend_cnt", idx), 32'(pend_cnt), 32'(x.cnt));
        chk($sformatf("v%0d stall_req", idx), 32'(stall_req), 32'(x.st));
    endtask
    initial begin
        reset = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0; chk_addr = '0;
        tick();
        tick();
        chk("rst grf_we", 32'(grf_we), 32'd0);
        chk("rst grf_addr", 32'(grf_addr), 32'd0);
        chk("rst grf_data", grf_data, 32'd0);
        chk("rst pend_cnt", 32'(pend_cnt), 32'd0);
        chk("rst stall_req", 32'(stall_req), 32'd0);
        chk("rst mdu_ready", 32'(mdu_ready), 32'd1);
        tbl.push_back(v(1, 1,5,'h1234, 0,0,0,   5, 1,0, 1,5,'h1234,0,0));
        tbl.push_back(v(1, 0,0,0,      0,0,0,   0, 1,0, 0,5,'h1234,0,0));
        tbl.push_back(v(1, 1,1,'h11,   1,8,'hA, 8, 1,0, 1,1,'h11,1,0));
        tbl.push_back(v(1, 1,2,'h22,   1,9,'hB, 8, 1,1, 1,2,'h22,2,0));
        tbl.push_back(v(1, 1,3,'h33,   1,10,'hC,9, 0,1, 1,3,'h33,2,0));
        tbl.push_back(v(1, 1,4,'h44,   0,0,0,   9, 0,1, 1,4,'h44,2,1));
        tbl.push_back(v(1, 1,6,'h66,   0,0,0,   0, 0,0, 1,6,'h66,2,1));
        tbl.push_back(v(1, 0,0,0,      0,0,0,   8, 0,1, 1,8,'hA,1,0));
        tbl.push_back(v(1, 0,0,0,      0,0,0,   8, 1,0, 1,9,'hB,0,0));
        tbl.push_back(v(1, 0,0,0,      0,0,0,   9, 1,0, 0,9,'hB,0,0));
        tbl.push_back(v(1, 0,0,0,      1,8,'hA, 8, 1,0, 0,9,'hB,1,0));
        tbl.push_back(v(1, 1,8,'hC,    0,0,0,   8, 1,1, 1,8,'hC,0,0));
        tbl.push_back(v(1, 0,0,0,      0,0,0,   8, 1,0, 0,8,'hC,0,0));
        tbl.push_back(v(1, 0,0,0,      1,0,'h55,0, 1,0, 0,8,'hC,0,0));
        tbl.push_back(v(1, 1,0,'h77,   0,0,0,   0, 1,0, 0,8,'hC,0,0));
        tbl.push_back(v(1, 0,0,0,      1,3,'h31,3, 1,0, 0,8,'hC,1,0));
        tbl.push_back(v(1, 0,0,0,      1,4,'h41,3, 1,1, 1,3,'h31,1,0));
        tbl.push_back(v(1, 0,0,0,      0,0,0,   4, 1,1, 1,4,'h41,0,0));
        tbl.push_back(v(1, 0,0,0,      1,7,'h71,0, 1,0, 0,4,'h41,1,0));
        tbl.push_back(v(1, 1,7,'h72,   1,7,'h73,7, 1,1, 1,7,'h72,1,0));
        tbl.push_back(v(1, 0,0,0,      0,0,0,   7, 1,1, 1,7,'h73,0,0));
        tbl.push_back(v(1, 0,0,0,      1,2,'h21,2, 1,0, 0,7,'h73,1,0));
        tbl.push_back(v(1, 1,0,'h99,   0,0,0,   2, 1,1, 1,2,'h21,0,0));
        foreach (tbl[i]) apply(tbl[i], i);
        // fill the FIFO under pipeline pressure, then reset while stalled
        apply(v(1, 1,1,'h11, 1,8,'hA, 0, 1,0, 1,1,'h11,1,0), 100);
        apply(v(1, 1,2,'h22, 1,9,'hB, 0, 1,0, 1,2,'h22,2,0), 101);
        pipe_we = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h33; mdu_valid = 1'b0;
        for (int n = 0; n < 8 && !stall_req; n++) tick();
        chk("seq stall_reached", 32'(stall_req), 32'd1);
        chk("seq full_before_reset", 32'(pend_cnt), 32'd2);
        reset = 1'b0; pipe_addr = 5'd12; pipe_data = 32'hDEAD;
        mdu_valid = 1'b1; mdu_addr = 5'd13; mdu_data = 32'hBEEF;
        tick();
        chk("seq rst pend_cnt", 32'(pend_cnt), 32'd0);
        chk("seq rst stall_req", 32'(stall_req), 32'd0);
        chk("seq rst grf_we", 32'(grf_we), 32'd0);
        chk("seq rst grf_addr", 32'(grf_addr), 32'd0);
        reset = 1'b1; pipe_we = 1'b0; mdu_valid = 1'b0; chk_addr = 5'd8;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk($sformatf("seq post%0d grf_we", n), 32'(grf_we), 32'd0);
            chk($sformatf("seq post%0d pend_cnt", n), 32'(pend_cnt), 32'd0);
            chk($sformatf("seq post%0d chk_hit", n), 32'(chk_hit), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 3: cycles a pending MDU entry may wait before stall_req asserts.
REQ-002 SHALL use one clock and a synchronous, active-low reset, with ports in this order:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset; 0 = reset
REQ-003 SHALL have the following remaining ports:
- pipe_we  in  1  WB-stage write request
- pipe_addr  in  5  WB-stage destination register
- pipe_data  in  32  WB-stage write data (selected DM/ALU/PC+8 value)
- mdu_valid  in  1  MDU result offered
- mdu_addr  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  MDU result accepted this cycle when high with mdu_valid
- chk_addr  in  5  register queried by hazard unit
- chk_hit  out  1  chk_addr matches a live pending entry, combinational
- grf_we  out  1  GRF write enable, registered
- grf_addr  out  5  GRF write address, registered
- grf_data  out  32  GRF write data, registered
- pend_cnt  out  2  live pending entries (0..2)
- stall_req  out  1  request for a pipeline bubble, registered

Function
REQ-004 SHALL share the single GRF write port between the WB stage and a 2-entry in-order MDU pending FIFO.
REQ-005 SHALL give the pipeline priority: a pipe_we with a nonzero pipe_addr always wins in that cycle.
REQ-006 SHALL pop and write the FIFO head in any cycle without a qualifying pipeline write, if the FIFO holds a live entry.
REQ-007 SHALL register grants: grf_we/addr/data reflect the cycle-N grant at the edge ending cycle N, giving a latency of 1.
REQ-008 SHALL drive grf_we=0 in cycles with no grant; grf_addr and grf_data then hold their previous values.
REQ-009 SHALL drive mdu_ready = (pend_cnt<2), computed from the current count only. A full FIFO rejects a push even in a cycle that pops.
REQ-010 SHALL, on a push with mdu_addr=0, complete the handshake and discard the entry; no count change and no write.
REQ-011 SHALL drop a pipe_we with pipe_addr=0: no grant, and FIFO pop proceeds.
REQ-012 SHALL, on a pipeline grant, kill every FIFO entry whose address equals pipe_addr. A killed entry leaves without a GRF write, so the newer write is never clobbered.
REQ-013 SHALL compare a same-cycle push against the post-kill contents only; the new entry survives.
REQ-014 SHALL allow a push and a pop in the same cycle when not full: count is unchanged and order is preserved.
REQ-015 SHALL implement FIFO occupancy as a state machine EMPTY/ONE/FULL driven by push, pop and kill, with kills applied before push.
REQ-016 SHALL keep a saturating age counter: it increments each cycle the head is live and not popped, and clears on pop, kill or empty.
REQ-017 SHALL set stall_req=1 at the edge where the age counter reaches STARVE_LIM; it clears at the edge after the head pops.
REQ-018 SHALL still let the pipeline win if pipe_we arrives while stall_req=1; the age counter then stays saturated.
REQ-019 SHALL set chk_hit only for live entries with a nonzero address.

Reset
REQ-020 SHALL, while reset=0 at a clk edge, clear the FIFO to EMPTY with all entries dead, and set age=0.
REQ-021 SHALL, during that same reset, clear grf_we, grf_addr, grf_data, stall_req and pend_cnt to 0.
REQ-022 SHALL drop a grant or push pending at a mid-operation reset: no GRF write occurs for it.

Structure
REQ-023 SHALL take the FIFO depth (2), register-address width (5) and data width (32) from the shared constants file, alongside the existing WB source-select codes.
REQ-024 SHALL contain one sub-module, wb_pend_fifo, holding the storage, kill logic and occupancy FSM. Arbitration, age counting and output registers stay in wb_arbiter.

Verification
REQ-025 SHALL cover: pipe_we=1, addr=5, data=0x1234 with FIFO empty -> next cycle grf_we=1, grf_addr=5, grf_data=0x1234.
REQ-026 SHALL cover: two MDU pushes (addr 8 = 0xA, addr 9 = 0xB) during continuous pipe writes -> third push sees mdu_ready=0.
REQ-027 SHALL cover the follow-on to REQ-026: pipeline continues -> stall_req=1 after 3 waits; pipe_we drops -> $8=0xA written, then $9=0xB.
REQ-028 SHALL cover: FIFO holds addr 8 = 0xA, then pipe writes addr 8 = 0xC -> grf writes 0xC only, pend_cnt drops to 0, chk_hit(8)=0.
REQ-029 SHALL cover: push with mdu_addr=0 -> mdu_ready=1, pend_cnt stays 0, no grf_we; separately pipe_we with addr 0 -> no grf_we.
REQ-030 SHALL cover: FIFO holding 2 entries and stall_req=1, then reset=0 for one cycle -> pend_cnt=0, stall_req=0, grf_we=0, and no late writes after release.
